// File: rtl/nn_job_controller.sv
// Job initiator for one nn forward-pass core: takes an operand pair, pulses nn
// enable, waits out the fixed nn latency, then presents the captured result.
module nn_job_controller #(
  parameter int DATAWIDTH   = 32,
  parameter int NN_LATENCY  = 5,
  parameter int LOAD_CYCLES = 9
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data_1,
  input  logic [DATAWIDTH-1:0] in_data_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_result,
  output logic                 out_ovf,
  output logic                 out_zero,
  output logic [2:0]           out_ovf_stage,
  output logic [2:0]           out_zero_stage,
  output logic                 nn_enable,
  output logic [DATAWIDTH-1:0] nn_input_1,
  output logic [DATAWIDTH-1:0] nn_input_2,
  input  logic [DATAWIDTH-1:0] nn_final_output,
  input  logic                 nn_total_ovf,
  input  logic                 nn_total_zero,
  input  logic [2:0]           nn_ovf_stage,
  input  logic [2:0]           nn_zero_stage,
  output logic [15:0]          job_count,
  output logic [15:0]          ovf_count
);

  typedef enum logic [2:0] {
    S_WAIT_LOAD = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_RUN       = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  localparam int CNT_MAX = (LOAD_CYCLES > NN_LATENCY) ? LOAD_CYCLES : NN_LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 2);
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES);
  localparam logic [CW-1:0] RUN_LAST  = CW'(NN_LATENCY);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic          out_fire;
  logic          run_done;

  // Both streams use strict valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high. in_ready is high only in S_IDLE and
  // out_valid only in S_HOLD, so neither side can transfer in any other state.
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign run_done = (state == S_RUN) && (cnt == RUN_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    nn_enable = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_WAIT_LOAD: begin
        if (cnt == LOAD_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_START;
      end
      S_START: begin
        nn_enable = 1'b1;
        state_nxt = S_RUN;
        cnt_nxt   = '0;
      end
      S_RUN: begin
        if (cnt == RUN_LAST) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_WAIT_LOAD;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_WAIT_LOAD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Operands stay on the nn inputs until the next accepted pair.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      nn_input_1 <= '0;
      nn_input_2 <= '0;
    end else if (accept) begin
      nn_input_1 <= in_data_1;
      nn_input_2 <= in_data_2;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_result     <= '0;
      out_ovf        <= 1'b0;
      out_zero       <= 1'b0;
      out_ovf_stage  <= 3'd0;
      out_zero_stage <= 3'd0;
    end else if (run_done) begin
      out_result     <= nn_final_output;
      out_ovf        <= nn_total_ovf;
      out_zero       <= nn_total_zero;
      out_ovf_stage  <= nn_ovf_stage;
      out_zero_stage <= nn_zero_stage;
    end
  end

  // job_count wraps; ovf_count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      job_count <= 16'd0;
      ovf_count <= 16'd0;
    end else if (out_fire) begin
      job_count <= job_count + 16'd1;
      if (out_ovf && (ovf_count != 16'hFFFF)) ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_nn_job_controller.sv
// Bench for nn_job_controller: a stand-in nn core, a timestamp-based reference
// model, a per-cycle compare process, and directed plus random stimulus.
module tb_nn_job_controller;

  localparam int DW         = 32;
  localparam int NN_LAT     = 5;
  localparam int LOAD_WAIT  = 10;
  localparam int RESULT_LAT = 7;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          ovf;
    logic          zero;
    logic [2:0]    os;
    logic [2:0]    zs;
  } nn_res_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data_1;
  logic [DW-1:0] in_data_2;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_ovf;
  logic          out_zero;
  logic [2:0]    out_ovf_stage;
  logic [2:0]    out_zero_stage;
  logic          nn_enable;
  logic [DW-1:0] nn_input_1;
  logic [DW-1:0] nn_input_2;
  logic [DW-1:0] nn_final_output;
  logic          nn_total_ovf;
  logic          nn_total_zero;
  logic [2:0]    nn_ovf_stage;
  logic [2:0]    nn_zero_stage;
  logic [15:0]   job_count;
  logic [15:0]   ovf_count;

  nn_job_controller #(.DATAWIDTH(DW), .NN_LATENCY(NN_LAT), .LOAD_CYCLES(9)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .out_zero(out_zero),
    .out_ovf_stage(out_ovf_stage), .out_zero_stage(out_zero_stage),
    .nn_enable(nn_enable), .nn_input_1(nn_input_1), .nn_input_2(nn_input_2),
    .nn_final_output(nn_final_output), .nn_total_ovf(nn_total_ovf),
    .nn_total_zero(nn_total_zero), .nn_ovf_stage(nn_ovf_stage),
    .nn_zero_stage(nn_zero_stage),
    .job_count(job_count), .ovf_count(ovf_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in nn function: signed add, saturating to all-ones on overflow.
  function automatic nn_res_t nn_fn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    nn_res_t       r;
    logic [DW-1:0] s;
    s      = a + b;
    r.ovf  = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
    r.res  = r.ovf ? {DW{1'b1}} : s;
    r.zero = !r.ovf && (s == '0);
    r.os   = r.ovf ? 3'd7 : r.res[2:0];
    r.zs   = r.zero ? 3'd1 : r.res[5:3];
    return r;
  endfunction

  // ---------------- stand-in nn core ----------------
  // Result is valid only in the single cycle before the controller must capture it.
  int en_cyc = -1000;
  always @(negedge clk) begin
    nn_res_t r;
    if (nn_enable) en_cyc = cyc;
    if (cyc == en_cyc + NN_LAT + 1) begin
      r = nn_fn(nn_input_1, nn_input_2);
      nn_final_output = r.res;
      nn_total_ovf    = r.ovf;
      nn_total_zero   = r.zero;
      nn_ovf_stage    = r.os;
      nn_zero_stage   = r.zs;
    end else begin
      nn_final_output = $urandom;
      nn_total_ovf    = 1'($urandom_range(0, 1));
      nn_total_zero   = 1'($urandom_range(0, 1));
      nn_ovf_stage    = 3'($urandom_range(0, 7));
      nn_zero_stage   = 3'($urandom_range(0, 7));
    end
  end

  // ---------------- reference model (event timestamps) ----------------
  int          ready_from = 1 << 30;
  bit          busy = 1'b0;
  int          acc = -1000;
  int          last_hs = -1000;
  bit          was_idle, was_hold;
  logic [DW-1:0] m_in1 = '0, m_in2 = '0;
  nn_res_t     m_pend = '0, m_out = '0;
  logic [15:0] m_jobs = '0, m_ovfs = '0;
  int          gap_q[$];

  always @(posedge clk) begin
    cyc++;
    if (!resetn) begin
      ready_from = cyc + LOAD_WAIT;
      busy   = 1'b0;
      m_in1  = '0;
      m_in2  = '0;
      m_out  = '0;
      m_jobs = '0;
      m_ovfs = '0;
    end else begin
      was_idle = !busy && (cyc - 1 >= ready_from);
      was_hold = busy && (cyc - 1 >= acc + RESULT_LAT);
      if (was_idle && in_valid) begin
        busy   = 1'b1;
        acc    = cyc;
        m_in1  = in_data_1;
        m_in2  = in_data_2;
        m_pend = nn_fn(in_data_1, in_data_2);
        gap_q.push_back(cyc - last_hs);
      end else if (was_hold && out_ready) begin
        busy    = 1'b0;
        last_hs = cyc;
        m_jobs++;
        if (m_out.ovf && m_ovfs != 16'hFFFF) m_ovfs++;
      end
      if (busy && cyc == acc + RESULT_LAT) m_out = m_pend;
    end
  end

  // ---------------- compare process ----------------
  int en_cnt = 0;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (nn_enable) en_cnt++;
      chk("in_ready",   in_ready,   !busy && cyc >= ready_from);
      chk("nn_enable",  nn_enable,  busy && cyc == acc);
      chk("out_valid",  out_valid,  busy && cyc >= acc + RESULT_LAT);
      chk("nn_input_1", nn_input_1, m_in1);
      chk("nn_input_2", nn_input_2, m_in2);
      chk("out_result", out_result, m_out.res);
      chk("out_flags",  {out_ovf, out_zero, out_ovf_stage, out_zero_stage},
                        {m_out.ovf, m_out.zero, m_out.os, m_out.zs});
      chk("job_count",  job_count,  m_jobs);
      chk("ovf_count",  ovf_count,  m_ovfs);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string nm);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, in_ready, 1'b1);
  endtask

  // Called right after resetn rises: counts cycles with in_ready low.
  task automatic count_load_wait(input string nm);
    int n = 0;
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, LOAD_WAIT);
  endtask

  task automatic do_job(input logic [DW-1:0] a, input logic [DW-1:0] b, input int stall,
                        output logic [DW-1:0] res, output logic ov, output int lat);
    in_valid  = 1'b1;
    in_data_1 = a;
    in_data_2 = b;
    wait_ready("accept_wait");
    @(negedge clk);
    in_valid  = 1'b0;
    in_data_1 = $urandom;
    in_data_2 = $urandom;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
    ov  = out_ovf;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] res;
  logic          ov;
  int            lat;
  int            en0;
  logic [DW-1:0] pa[3] = '{32'd1, 32'd20, 32'hFFFF_FFF0};
  logic [DW-1:0] pb[3] = '{32'd2, 32'd300, 32'd5};

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  in_ready,   1'b0);
    chk("rst_out_valid", out_valid,  1'b0);
    chk("rst_job_count", job_count,  16'd0);
    resetn = 1'b1;
    count_load_wait("load_wait_poweron");

    en0 = en_cnt;
    do_job(32'd100, 32'd50, 0, res, ov, lat);
    chk("job1_latency", lat, RESULT_LAT);
    chk("job1_result",  res, 32'd150);
    chk("job1_ovf",     ov, 1'b0);
    chk("job1_enable_pulses", en_cnt - en0, 1);
    chk("job1_count",   job_count, 16'd1);

    do_job(32'd100, 32'd50, 10, res, ov, lat);
    chk("stall_result", res, 32'd150);
    chk("stall_count",  job_count, 16'd2);

    do_job(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, res, ov, lat);
    chk("ovf_result", res, 32'hFFFF_FFFF);
    chk("ovf_flag",   ov, 1'b1);
    chk("ovf_count1", ovf_count, 16'd1);

    do_job(32'hFFFF_FFFB, 32'd5, 2, res, ov, lat);
    chk("zero_result", res, 32'd0);
    chk("zero_flag",   out_zero, 1'b1);

    // Three pairs back to back with in_valid never dropping.
    out_ready = 1'b1;
    gap_q.delete();
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_data_1 = pa[i];
      in_data_2 = pb[i];
      wait_ready("pipe_accept");
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (RESULT_LAT + 3) @(negedge clk);
    chk("pipe_count",   job_count, 16'd7);
    chk("pipe_last",    out_result, 32'hFFFF_FFF5);
    chk("pipe_gaps_n",  gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      chk("pipe_gap2", gap_q[1], 1);
      chk("pipe_gap3", gap_q[2], 1);
    end
    out_ready = 1'b0;

    // Reset while the nn is running: the job must vanish.
    in_valid  = 1'b1;
    in_data_1 = 32'd7;
    in_data_2 = 32'd8;
    wait_ready("abort_accept");
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_result",    out_result, 32'd0);
    chk("abort_nn_input",  nn_input_1, 32'd0);
    chk("abort_job_count", job_count, 16'd0);
    resetn = 1'b1;
    count_load_wait("load_wait_abort");
    repeat (12) @(negedge clk);
    chk("abort_no_result", job_count, 16'd0);

    // Random traffic, including occasional resets and overflow-prone operands.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      resetn    = ($urandom_range(0, 499) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0, 1: begin
          in_data_1 = 32'h7000_0000 | $urandom_range(0, 32'h0FFF_FFFF);
          in_data_2 = 32'h7000_0000 | $urandom_range(0, 32'h0FFF_FFFF);
        end
        2: begin
          in_data_1 = $urandom;
          in_data_2 = -in_data_1;
        end
        default: begin
          in_data_1 = $urandom;
          in_data_2 = $urandom;
        end
      endcase
    end
    resetn    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
